// File: rtl/trace_pkg.sv
// Shared types and constants for the trace frame transmitter.
// The frame-length helper accounts for the trailing checksum byte when TRACE_CHECKSUM_EN is defined.
package trace_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_RD   = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  localparam logic [7:0]  HEADER_DEF     = 8'hA5;
  localparam int unsigned BLOCK_SIZE_DEF = 32;
  localparam int unsigned KEY_SIZE_DEF   = 64;
  localparam int unsigned SAMPLES_DEF    = 1024;
  localparam int unsigned ADDR_W_DEF     = 10;

  // Byte count of one record segment (PT, key or CT) from its width in bits.
  function automatic int unsigned seg_bytes(input int unsigned bits);
    return bits / 8;
  endfunction

  function automatic int unsigned pt_bytes(input int unsigned block_size);
    return seg_bytes(block_size);
  endfunction

  function automatic int unsigned key_bytes(input int unsigned key_size);
    return seg_bytes(key_size);
  endfunction

  function automatic int unsigned ct_bytes(input int unsigned block_size);
    return seg_bytes(block_size);
  endfunction

  function automatic int unsigned frame_len(input int unsigned block_size,
                                            input int unsigned key_size,
                                            input int unsigned samples);
    int unsigned n;
    n = 1 + pt_bytes(block_size) + key_bytes(key_size) + ct_bytes(block_size) + samples;
`ifdef TRACE_CHECKSUM_EN
    n = n + 1;
`endif
    return n;
  endfunction

endpackage

// File: rtl/trace_frame_tx.sv
// Streams header, PT, key, CT and trace RAM samples over the uart_tx byte handshake.
// Define TRACE_CHECKSUM_EN to append an XOR checksum of all bytes after the header.
module trace_frame_tx
  import trace_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int unsigned KEY_SIZE   = KEY_SIZE_DEF,
  parameter int unsigned SAMPLES    = SAMPLES_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter logic [7:0]  HEADER     = HEADER_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BLOCK_SIZE-1:0] pt,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic [BLOCK_SIZE-1:0] ct,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_data,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N_REC = 1 + pt_bytes(BLOCK_SIZE) + key_bytes(KEY_SIZE) + ct_bytes(BLOCK_SIZE);
  localparam int unsigned REC_W = 8 * N_REC;
  localparam int unsigned IDX_W = $clog2(N_REC + 1);
  localparam int unsigned OFS_W = $clog2(REC_W);
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t              r_state, w_state_nx;
  logic [REC_W-1:0]    r_rec, w_rec_nx;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [7:0]          r_tx_byte, w_tx_byte_nx;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nx;
  logic                r_tx_dv, w_tx_dv_nx;
  logic                r_busy, w_busy_nx;
  logic                r_done, w_done_nx;
`ifdef TRACE_CHECKSUM_EN
  logic [7:0]          r_csum, w_csum_nx;
`endif

  logic [OFS_W-1:0]    w_ofs;
  logic [7:0]          w_rec_byte;
  logic                w_in_rec, w_in_smp, w_last_smp;
  logic [CNT_W-1:0]    w_cnt_inc;

  // Record byte 0 (header) sits in the top byte of r_rec.
  assign w_ofs      = OFS_W'(REC_W - 8) - OFS_W'({r_idx, 3'b000});
  assign w_rec_byte = r_rec[w_ofs +: 8];
  assign w_in_rec   = r_idx < IDX_W'(N_REC);
  assign w_in_smp   = r_cnt < CNT_W'(SAMPLES);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_last_smp = w_cnt_inc == CNT_W'(SAMPLES);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nx = S_LOAD;
      S_LOAD: begin
        if (w_in_rec)      w_state_nx = S_SEND;
        else if (w_in_smp) w_state_nx = S_RD;
        else               w_state_nx = S_SEND;
      end
      S_RD:   w_state_nx = S_SEND;
      S_SEND: w_state_nx = S_WAIT;
      S_WAIT: if (tx_done) w_state_nx = S_NEXT;
      S_NEXT: begin
        if (w_in_rec) w_state_nx = S_LOAD;
`ifdef TRACE_CHECKSUM_EN
        else if (w_in_smp) w_state_nx = S_LOAD;
`else
        else if (w_in_smp) w_state_nx = w_last_smp ? S_FIN : S_LOAD;
`endif
        else               w_state_nx = S_FIN;
      end
      S_FIN:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs.
  always_comb begin
    w_rec_nx      = r_rec;
    w_idx_nx      = r_idx;
    w_cnt_nx      = r_cnt;
    w_tx_byte_nx  = r_tx_byte;
    w_mem_addr_nx = r_mem_addr;
`ifdef TRACE_CHECKSUM_EN
    w_csum_nx     = r_csum;
`endif
    w_tx_dv_nx    = (w_state_nx == S_SEND);
    w_busy_nx     = (w_state_nx != S_IDLE) && (w_state_nx != S_FIN);
    w_done_nx     = (w_state_nx == S_FIN);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rec_nx      = {HEADER, pt, key, ct};
          w_idx_nx      = '0;
          w_cnt_nx      = '0;
          w_mem_addr_nx = '0;
`ifdef TRACE_CHECKSUM_EN
          w_csum_nx     = '0;
`endif
        end
      end
      S_LOAD: begin
        if (w_in_rec) begin
          w_tx_byte_nx = w_rec_byte;
`ifdef TRACE_CHECKSUM_EN
          if (r_idx != '0) w_csum_nx = r_csum ^ w_rec_byte;
`endif
        end
`ifdef TRACE_CHECKSUM_EN
        else if (!w_in_smp) begin
          w_tx_byte_nx = r_csum;
        end
`endif
      end
      S_RD: begin
        w_tx_byte_nx = mem_data;
`ifdef TRACE_CHECKSUM_EN
        w_csum_nx    = r_csum ^ mem_data;
`endif
      end
      S_NEXT: begin
        if (w_in_rec) begin
          w_idx_nx = r_idx + IDX_W'(1);
        end else if (w_in_smp) begin
          w_cnt_nx = w_cnt_inc;
          // Hold the final address rather than wrapping to 0 after the last sample.
          if (!w_last_smp) w_mem_addr_nx = w_cnt_inc[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rec      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_tx_byte  <= '0;
      r_mem_addr <= '0;
      r_tx_dv    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef TRACE_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_rec      <= w_rec_nx;
      r_idx      <= w_idx_nx;
      r_cnt      <= w_cnt_nx;
      r_tx_byte  <= w_tx_byte_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_tx_dv    <= w_tx_dv_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
`ifdef TRACE_CHECKSUM_EN
      r_csum     <= w_csum_nx;
`endif
    end
  end

  assign mem_addr = r_mem_addr;
  assign tx_dv    = r_tx_dv;
  assign tx_byte  = r_tx_byte;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_trace_frame_tx.sv
// Scoreboard bench for trace_frame_tx: expected frame bytes are queued at start and popped on tx_dv.
// Honours TRACE_CHECKSUM_EN for the trailing checksum byte.
module tb_trace_frame_tx;

  localparam int NREC = 17;
  localparam int NSMP = 1024;
`ifdef TRACE_CHECKSUM_EN
  localparam int FLEN = 1042;
`else
  localparam int FLEN = 1041;
`endif

  localparam logic [31:0] PT1  = 32'h01234567;
  localparam logic [63:0] KEY1 = 64'h1918111009080100;
  localparam logic [31:0] CT1  = 32'h89ABCDEF;
  localparam logic [31:0] PT2  = 32'hDEADBEEF;
  localparam logic [63:0] KEY2 = 64'h0F1E2D3C4B5A6978;
  localparam logic [31:0] CT2  = 32'h5A5AC3C3;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] pt, ct;
  logic [63:0] key;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done = 1'b0;
  logic        busy, done;

  logic [7:0]  ram [NSMP];
  int          exp_q[$];
  int          cyc = 0;
  int          n_pass = 0, n_chk = 0;
  int          byte_idx = 0, start_cyc = 0, last_txd_cyc = 0, done_seen = 0;
  int          pend_at = 0;
  bit          pend = 1'b0;

  trace_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pt       (pt),
    .key      (key),
    .ct       (ct),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data <= ram[mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [63:0] k, input logic [31:0] c);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(32'hA5);
    for (int i = 0; i < 4; i++) begin b = p[31-8*i -: 8]; exp_q.push_back(int'(b)); cs ^= b; end
    for (int i = 0; i < 8; i++) begin b = k[63-8*i -: 8]; exp_q.push_back(int'(b)); cs ^= b; end
    for (int i = 0; i < 4; i++) begin b = c[31-8*i -: 8]; exp_q.push_back(int'(b)); cs ^= b; end
    for (int i = 0; i < NSMP; i++) begin b = ram[i]; exp_q.push_back(int'(b)); cs ^= b; end
`ifdef TRACE_CHECKSUM_EN
    exp_q.push_back(int'(cs));
`endif
  endtask

  // UART model (tx_done 3 cycles after tx_dv) plus output monitor, both mid-cycle.
  always @(negedge clk) begin
    int e;
    int gap_exp;
    bit is_smp;
    tx_done = 1'b0;
    if (pend && cyc == pend_at) begin
      tx_done = 1'b1;
      pend = 1'b0;
      last_txd_cyc = cyc;
    end
    if (tx_dv) begin
      is_smp = (byte_idx >= NREC) && (byte_idx < NREC + NSMP);
      if (exp_q.size() == 0) begin
        check("extra_tx_dv", 64'(tx_byte), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("byte[%0d]", byte_idx), 64'(tx_byte), 64'(e));
      end
      if (byte_idx == 0) begin
        check("start_to_dv", 64'(cyc - start_cyc), 64'd2);
      end else begin
        gap_exp = is_smp ? 3 : 2;
        check($sformatf("gap[%0d]", byte_idx), 64'(cyc - last_txd_cyc - 1), 64'(gap_exp));
      end
      check("busy_on_dv", 64'(busy), 64'd1);
      if (is_smp) check($sformatf("addr[%0d]", byte_idx), 64'(mem_addr), 64'(byte_idx - NREC));
      byte_idx++;
      pend = 1'b1;
      pend_at = cyc + 3;
    end
    if (done) begin
      done_seen++;
      check("done_latency", 64'(cyc - last_txd_cyc), 64'd2);
      check("busy_at_done", 64'(busy), 64'd0);
      check("frame_len", 64'(byte_idx), 64'(FLEN));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("addr_no_wrap", 64'(mem_addr), 64'(NSMP - 1));
    end
  end

  task automatic start_frame(input logic [31:0] p, input logic [63:0] k, input logic [31:0] c);
    @(posedge clk); #1;
    push_frame(p, k, c);
    byte_idx = 0;
    pt = p; key = k; ct = c;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    check("done_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_bytes(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (byte_idx >= n) begin ok = 1'b1; break; end
    end
    check("byte_timeout", 64'(ok), 64'd1);
  endtask

  // A start while busy with different inputs must leave the stream untouched.
  task automatic poke_start();
    @(posedge clk); #1;
    pt = ~pt; key = ~key; ct = ~ct;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_hold", 64'(busy), 64'd1);
  endtask

  initial begin
    bit found;
    int late_dv;
    for (int i = 0; i < NSMP; i++) ram[i] = 8'(i);
    rst = 1'b1; start = 1'b0; pt = '0; key = '0; ct = '0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_tx_dv", 64'(tx_dv), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    check("rst_beats_start", 64'(busy), 64'd0);

    start_frame(PT1, KEY1, CT1);
    wait_bytes(5);
    poke_start();
    wait_bytes(100);
    poke_start();
    wait_done(12000);

    start_frame(PT2, KEY2, CT2);
    wait_done(12000);

    start_frame(PT1, KEY1, CT1);
    found = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (tx_dv && mem_addr == 10'd500) begin found = 1'b1; break; end
    end
    check("reach_sample_500", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx_dv", 64'(tx_dv), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mem_addr", 64'(mem_addr), 64'd0);
    check("abort_tx_byte", 64'(tx_byte), 64'd0);
    late_dv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_dv || busy) late_dv++;
    end
    check("late_tx_done_ignored", 64'(late_dv), 64'd0);

    start_frame(PT1, KEY1, CT1);
    wait_done(12000);
    repeat (5) @(negedge clk);
    check("done_pulse_count", 64'(done_seen), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
